// File: rtl/rssb_loader.sv
// Serial program loader for an RSSB core: takes a length byte, N data bytes and a checksum byte,
// writes the data into memory, then releases the core from reset only if the checksum matches.
module rssb_loader #(
   parameter int unsigned      WIDTH      = 8,
   parameter logic [WIDTH-1:0] START_ADDR = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             reload,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             cpu_rst,
   output logic             done,
   output logic             err
);

   typedef enum logic [2:0] {StLen, StData, StCsum, StRun, StErr} state_e;

   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] len_q, len_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] addr_d, wdata_d;
   logic             we_d;
   logic             accept;

   // in_ready is forced low combinationally while rst is held
   assign in_ready = ~rst & ((state_q == StLen) | (state_q == StData) | (state_q == StCsum));
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      we_d    = 1'b0;
      case (state_q)
         StLen: begin
            if (accept) begin
               len_d   = in_data;
               cnt_d   = '0;
               sum_d   = '0;
               state_d = (in_data == '0) ? StCsum : StData;
            end
         end
         StData: begin
            if (accept) begin
               we_d    = 1'b1;
               addr_d  = START_ADDR + cnt_q;
               wdata_d = in_data;
               sum_d   = sum_q + in_data;
               if (cnt_q == len_q - One) begin
                  state_d = StCsum;
               end else begin
                  cnt_d = cnt_q + One;
               end
            end
         end
         StCsum: begin
            if (accept) begin
               state_d = (in_data == sum_q) ? StRun : StErr;
            end
         end
         StRun, StErr: begin
            if (reload) begin
               state_d = StLen;
            end
         end
         default: state_d = StLen;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StLen;
         len_q     <= '0;
         cnt_q     <= '0;
         sum_q     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rst   <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         mem_we    <= we_d;
         mem_addr  <= addr_d;
         mem_wdata <= wdata_d;
         // Registered from next state so the core leaves reset on the edge that enters RUN
         cpu_rst   <= (state_d != StRun);
         done      <= (state_d == StRun);
         err       <= (state_d == StErr);
      end
   end

endmodule

// File: tb/tb_rssb_loader.sv
// Directed bench for rssb_loader; a second instance with START_ADDR=FE shares the stimulus
// so address wrap can be observed alongside the default instance.
module tb_rssb_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       reload;

   logic       in_ready0, mem_we0, cpu_rst0, done0, err0;
   logic [7:0] mem_addr0, mem_wdata0;
   logic       in_ready1, mem_we1, cpu_rst1, done1, err1;
   logic [7:0] mem_addr1, mem_wdata1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rssb_loader #(.WIDTH(8), .START_ADDR(8'h00)) dut0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
      .reload(reload), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .cpu_rst(cpu_rst0), .done(done0), .err(err0)
   );

   rssb_loader #(.WIDTH(8), .START_ADDR(8'hFE)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
      .reload(reload), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .cpu_rst(cpu_rst1), .done(done1), .err(err1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one byte for exactly one edge; returns #1 after that edge
   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reload();
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      in_data  = 8'h00;
      in_valid = 1'b0;
      reload   = 1'b0;
      #3;
      chk("rst_mem_we", mem_we0, 1'b0);
      chk("rst_mem_addr", mem_addr0, 8'h00);
      chk("rst_mem_wdata", mem_wdata0, 8'h00);
      chk("rst_cpu_rst", cpu_rst0, 1'b1);
      chk("rst_done", done0, 1'b0);
      chk("rst_err", err0, 1'b0);
      chk("rst_in_ready", in_ready0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready0, 1'b1);

      // Good load: 03,11,22,33,66
      send(8'h03);
      chk("a_len_we", mem_we0, 1'b0);
      send(8'h11);
      chk("a_w0_we", mem_we0, 1'b1);
      chk("a_w0_addr", mem_addr0, 8'h00);
      chk("a_w0_data", mem_wdata0, 8'h11);
      send(8'h22);
      chk("a_w1_we", mem_we0, 1'b1);
      chk("a_w1_addr", mem_addr0, 8'h01);
      chk("a_w1_data", mem_wdata0, 8'h22);
      send(8'h33);
      chk("a_w2_we", mem_we0, 1'b1);
      chk("a_w2_addr", mem_addr0, 8'h02);
      chk("a_w2_data", mem_wdata0, 8'h33);
      chk("a_csum_cpu_rst", cpu_rst0, 1'b1);
      chk("a_csum_done", done0, 1'b0);
      send(8'h66);
      chk("a_run_we", mem_we0, 1'b0);
      chk("a_run_cpu_rst", cpu_rst0, 1'b0);
      chk("a_run_done", done0, 1'b1);
      chk("a_run_err", err0, 1'b0);
      chk("a_run_ready", in_ready0, 1'b0);
      idle(1);
      chk("a_hold_addr", mem_addr0, 8'h02);
      chk("a_hold_data", mem_wdata0, 8'h33);
      chk("a_hold_done", done0, 1'b1);
      do_reload();
      chk("a_reload_done", done0, 1'b0);
      chk("a_reload_cpu_rst", cpu_rst0, 1'b1);
      chk("a_reload_ready", in_ready0, 1'b1);

      // Bad checksum: 02,05,07,00 (sum is 0C)
      send(8'h02);
      send(8'h05);
      chk("b_w0_addr", mem_addr0, 8'h00);
      chk("b_w0_data", mem_wdata0, 8'h05);
      send(8'h07);
      chk("b_w1_we", mem_we0, 1'b1);
      chk("b_w1_addr", mem_addr0, 8'h01);
      send(8'h00);
      chk("b_err", err0, 1'b1);
      chk("b_err_cpu_rst", cpu_rst0, 1'b1);
      chk("b_err_done", done0, 1'b0);
      chk("b_err_ready", in_ready0, 1'b0);
      send(8'h01);
      chk("b_err_ignore_we", mem_we0, 1'b0);
      chk("b_err_stays", err0, 1'b1);
      do_reload();
      chk("b_reload_err", err0, 1'b0);
      chk("b_reload_ready", in_ready0, 1'b1);

      // Empty program: 00,00
      send(8'h00);
      chk("c_len_we", mem_we0, 1'b0);
      send(8'h00);
      chk("c_csum_we", mem_we0, 1'b0);
      chk("c_done", done0, 1'b1);
      chk("c_cpu_rst", cpu_rst0, 1'b0);
      do_reload();

      // Address wrap on the FE instance: 03,01,02,03,06
      send(8'h03);
      send(8'h01);
      chk("d_w0_addr", mem_addr1, 8'hFE);
      chk("d_w0_we", mem_we1, 1'b1);
      send(8'h02);
      chk("d_w1_addr", mem_addr1, 8'hFF);
      send(8'h03);
      chk("d_w2_addr", mem_addr1, 8'h00);
      chk("d_w2_data", mem_wdata1, 8'h03);
      send(8'h06);
      chk("d_done", done1, 1'b1);
      chk("d_done0", done0, 1'b1);
      do_reload();

      // Reset mid-load: 04,01,02 then rst
      send(8'h04);
      send(8'h01);
      send(8'h02);
      chk("e_pre_we", mem_we0, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("e_rst_we", mem_we0, 1'b0);
      chk("e_rst_addr", mem_addr0, 8'h00);
      chk("e_rst_cpu_rst", cpu_rst0, 1'b1);
      chk("e_rst_ready", in_ready0, 1'b0);
      idle(1);
      rst = 1'b0;
      #1;
      chk("e_rel_ready", in_ready0, 1'b1);
      send(8'h01);
      send(8'hAA);
      chk("e_w0_we", mem_we0, 1'b1);
      chk("e_w0_addr", mem_addr0, 8'h00);
      chk("e_w0_data", mem_wdata0, 8'hAA);
      send(8'hAA);
      chk("e_done", done0, 1'b1);
      do_reload();

      // Gapped stream 03,11,22,33,66 with stalls and a stray reload in DATA
      send(8'h03);
      idle(2);
      send(8'h11);
      chk("f_w0_addr", mem_addr0, 8'h00);
      idle(1);
      chk("f_gap_we", mem_we0, 1'b0);
      chk("f_gap_addr", mem_addr0, 8'h00);
      chk("f_gap_data", mem_wdata0, 8'h11);
      do_reload();
      chk("f_reload_ignored_ready", in_ready0, 1'b1);
      send(8'h22);
      chk("f_w1_we", mem_we0, 1'b1);
      chk("f_w1_addr", mem_addr0, 8'h01);
      idle(3);
      send(8'h33);
      chk("f_w2_addr", mem_addr0, 8'h02);
      chk("f_w2_data", mem_wdata0, 8'h33);
      idle(1);
      chk("f_csum_cpu_rst", cpu_rst0, 1'b1);
      send(8'h66);
      chk("f_done", done0, 1'b1);
      chk("f_cpu_rst", cpu_rst0, 1'b0);
      chk("f_err", err0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
